axi_bresp_gen: RTL and testbench
================================

// Module: axi_bresp_gen
// PURPOSE
//  AXI-side consumer of the AHB write-response FIFO. It pops per-beat 2-bit AHB HRESP codes from the FIFO.
//  It merges all beats of one AXI write burst into a single response.
//  It drives the AXI B channel (BID/BRESP/BVALID) with a BREADY handshake.
//  The ID/length of each accepted AW transaction is queued internally, so responses return in AW order.
// PARAMETERS
//  ID_W      4   width of AXI write ID
//  OST_DEPTH 4   outstanding-AW queue depth (power of 2, >=2)
// PORTS
//  rclk          in   1     clock (read-side clock of the response FIFO)
//  reset         in   1     synchronous, active-high reset
//  aw_push       in   1     pulse: AW transaction accepted by bridge; capture aw_id/aw_len
//  aw_id         in   ID_W  AWID of accepted transaction
//  aw_len        in   8     AWLEN (beats-1) of accepted transaction
//  aw_full       out  1     outstanding queue full; upstream must not assert aw_push
//  ovf_err       out  1     sticky: aw_push seen while aw_full
//  resp_empty    in   1     response FIFO empty flag
//  resp_data     in   2     FIFO data_out; valid only in the cycle resp_read_en=1 and resp_empty=0
//  resp_read_en  out  1     FIFO pop request
//  bid           out  ID_W  AXI BID
//  bresp         out  2     AXI BRESP
//  bvalid        out  1     AXI BVALID
//  bready        in   1     AXI BREADY
// BEHAVIOUR
//  Reset (sync, on rclk edge with reset=1):
//   - state=IDLE; queue empty.
//   - bvalid=0, bid=0, bresp=00, resp_read_en=0, aw_full=0, ovf_err=0.
//   - Beat counter and error accumulator cleared.
//   - Reset mid-burst discards queue and partial merge; FIFO contents are not touched.
//  Outstanding queue:
//   - Circular buffer of {id,len}; count 0..OST_DEPTH; aw_full = (count==OST_DEPTH).
//   - Push when aw_push & !aw_full. Pop at last-beat consume (see COLLECT).
//   - Simultaneous push+pop: both occur, count unchanged.
//   - Push while full: dropped, ovf_err<=1 until reset.
//  HRESP->BRESP map:
//   - 00 OKAY -> 00 OKAY; 01 ERROR -> 10 SLVERR; 10 RETRY / 11 SPLIT -> 10 SLVERR.
//   - Burst result = SLVERR if any beat is non-OKAY, else OKAY.
//  FSM:
//   - IDLE: if count!=0, beat_cnt<=head.len and err_acc<=0 -> COLLECT.
//   - COLLECT:
//     - resp_read_en = !resp_empty (combinational); resp_data is sampled the same cycle.
//     - Each pop: err_acc |= (resp_data!=00).
//     - Pop with beat_cnt!=0: beat_cnt--.
//     - Pop with beat_cnt==0 (last beat): bid<=head.id, bresp<=merged(err_acc|this beat), bvalid<=1, dequeue head -> RESP.
//   - RESP:
//     - bvalid, bid and bresp are held stable until bready=1.
//     - On the bready=1 edge: bvalid<=0 -> IDLE.
//   - resp_read_en=0 in IDLE and RESP; FIFO entries with no outstanding AW stay unread.
//  Latency:
//   - Last-beat pop in cycle N -> bvalid=1 in cycle N+1.
//   - bvalid can be accepted in N+1.
//   - Next burst starts COLLECT one IDLE cycle later.
//  Widths: beat_cnt is 8 bits; aw_len=0 is a single beat; aw_len=255 gives 256 beats, no overflow.
//  resp_empty toggling mid-burst only stalls COLLECT; the beat count is preserved.
// TESTING
//  T1: aw_push id=3 len=0; FIFO {00} -> one resp_read_en pulse; next cycle bvalid=1 bid=3 bresp=00; bready=1 clears it.
//  T2: id=5 len=3; FIFO {00,00,01,00} -> exactly 4 pops; single B with bid=5 bresp=10.
//  T3: push ids 1,2,3,4 (len=0), FIFO empty -> aw_full=1; 5th push -> ovf_err=1, queue unchanged; 4 FIFO entries -> B ids 1,2,3,4 in order.
//  T4: bready=0 for 10 cycles with B pending and further FIFO data -> bvalid/bid/bresp stable, resp_read_en=0 throughout.
//  T5: FIFO data present with no AW queued -> resp_read_en stays 0; later aw_push id=7 len=0 -> pop, B bid=7.
//  T6: reset asserted after 2 of 4 beats -> next cycle bvalid=0, aw_full=0; new id=9 len=0 -> B bid=9 bresp from first pop.

Source files
------------

// File: rtl/axi_bresp_gen.sv
// AXI write-response generator: merges per-beat AHB HRESP codes popped from the
// response FIFO into one B-channel response per burst, returned in AW order.
module axi_bresp_gen #(
    parameter int unsigned ID_W      = 4,
    parameter int unsigned OST_DEPTH = 4
) (
    input  logic            rclk,
    input  logic            reset,
    input  logic            aw_push,
    input  logic [ID_W-1:0] aw_id,
    input  logic [7:0]      aw_len,
    output logic            aw_full,
    output logic            ovf_err,
    input  logic            resp_empty,
    input  logic [1:0]      resp_data,
    output logic            resp_read_en,
    output logic [ID_W-1:0] bid,
    output logic [1:0]      bresp,
    output logic            bvalid,
    input  logic            bready
);

    localparam int unsigned PTR_W = $clog2(OST_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(OST_DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        RESP    = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [ID_W-1:0]  q_id  [OST_DEPTH];
    logic [7:0]       q_len [OST_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic [7:0]       beat_cnt;
    logic             err_acc;

    logic q_push, q_pop, beat_err, last_beat;

    assign aw_full   = (count == CNT_FULL);
    assign q_push    = aw_push && !aw_full;
    assign beat_err  = (resp_data != 2'b00);
    assign last_beat = (beat_cnt == 8'd0);
    assign q_pop     = resp_read_en && last_beat;

    always_ff @(posedge rclk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        resp_read_en = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) state_nxt = COLLECT;
            end
            COLLECT: begin
                resp_read_en = !resp_empty;
                if (!resp_empty && last_beat) state_nxt = RESP;
            end
            RESP: begin
                if (bready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Queue storage carries no reset; validity is tracked by count/pointers.
    always_ff @(posedge rclk) begin
        if (q_push) begin
            q_id[wr_ptr]  <= aw_id;
            q_len[wr_ptr] <= aw_len;
        end
    end

    always_ff @(posedge rclk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ovf_err  <= 1'b0;
            beat_cnt <= '0;
            err_acc  <= 1'b0;
            bid      <= '0;
            bresp    <= 2'b00;
            bvalid   <= 1'b0;
        end else begin
            if (q_push)             wr_ptr  <= wr_ptr + PTR_ONE;
            if (q_pop)              rd_ptr  <= rd_ptr + PTR_ONE;
            if (aw_push && aw_full) ovf_err <= 1'b1;

            case ({q_push, q_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase

            case (state)
                IDLE: begin
                    if (count != '0) begin
                        beat_cnt <= q_len[rd_ptr];
                        err_acc  <= 1'b0;
                    end
                end
                COLLECT: begin
                    if (resp_read_en) begin
                        if (!last_beat) begin
                            beat_cnt <= beat_cnt - 8'd1;
                            err_acc  <= err_acc | beat_err;
                        end else begin
                            // Any non-OKAY HRESP (ERROR/RETRY/SPLIT) maps to SLVERR.
                            bid    <= q_id[rd_ptr];
                            bresp  <= {err_acc | beat_err, 1'b0};
                            bvalid <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    if (bready) bvalid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_bresp_gen.sv
// Scoreboard bench for axi_bresp_gen: a behavioural response FIFO feeds the DUT,
// expected B responses are queued at stimulus time and checked by a monitor.
module tb_axi_bresp_gen;

    logic       rclk = 1'b0;
    logic       reset = 1'b1;
    logic       aw_push = 1'b0;
    logic [3:0] aw_id = '0;
    logic [7:0] aw_len = '0;
    logic       aw_full, ovf_err;
    logic       resp_empty = 1'b1;
    logic [1:0] resp_data = 2'b00;
    logic       resp_read_en;
    logic [3:0] bid;
    logic [1:0] bresp;
    logic       bvalid;
    logic       bready = 1'b1;

    axi_bresp_gen #(.ID_W(4), .OST_DEPTH(4)) dut (
        .rclk(rclk), .reset(reset),
        .aw_push(aw_push), .aw_id(aw_id), .aw_len(aw_len),
        .aw_full(aw_full), .ovf_err(ovf_err),
        .resp_empty(resp_empty), .resp_data(resp_data), .resp_read_en(resp_read_en),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 rclk = ~rclk;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } exp_t;

    logic [1:0] fifo_q[$];
    exp_t       exp_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         pop_cnt  = 0;
    int         cyc      = 0;
    int         last_pop = -10;
    logic       bv_prev  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural response FIFO: pop decided at negedge, applied just after posedge.
    initial begin
        logic       take;
        logic [1:0] dummy;
        forever begin
            @(negedge rclk);
            take = resp_read_en && !resp_empty;
            @(posedge rclk);
            #2;
            if (take && fifo_q.size() > 0) dummy = fifo_q.pop_front();
            resp_empty = (fifo_q.size() == 0);
            resp_data  = (fifo_q.size() > 0) ? fifo_q[0] : 2'b00;
        end
    end

    // Monitor: B handshakes against the scoreboard, plus last-pop-to-bvalid latency.
    always @(negedge rclk) begin
        exp_t e;
        cyc++;
        if (bvalid && !bv_prev) chk("b_latency", cyc, last_pop + 1);
        bv_prev = bvalid;
        if (resp_read_en && !resp_empty) begin
            last_pop = cyc;
            pop_cnt++;
        end
        if (bvalid && bready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_b: got bid=%0h bresp=%0h expected no response", bid, bresp);
            end else begin
                e = exp_q.pop_front();
                chk("bid", bid, e.id);
                chk("bresp", bresp, e.resp);
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge rclk);
        #1;
    endtask

    task automatic push_aw(input logic [3:0] id, input logic [7:0] len);
        tick();
        aw_push = 1'b1;
        aw_id   = id;
        aw_len  = len;
        tick();
        aw_push = 1'b0;
    endtask

    task automatic expect_b(input logic [3:0] id, input logic [1:0] resp);
        exp_q.push_back('{id: id, resp: resp});
    endtask

    task automatic drain(input string name, input int max);
        int n = 0;
        while (exp_q.size() != 0 && n < max) begin
            tick();
            n++;
        end
        tick();
        chk(name, exp_q.size(), 0);
    endtask

    initial begin
        int n;
        tick(2);
        reset = 1'b0;
        chk("rst_bvalid", bvalid, 0);
        chk("rst_bid", bid, 0);
        chk("rst_bresp", bresp, 0);
        chk("rst_read_en", resp_read_en, 0);
        chk("rst_aw_full", aw_full, 0);
        chk("rst_ovf_err", ovf_err, 0);

        // T1: single beat OKAY
        fifo_q.push_back(2'b00);
        expect_b(4'd3, 2'b00);
        pop_cnt = 0;
        push_aw(4'd3, 8'd0);
        drain("t1_drain", 50);
        chk("t1_pops", pop_cnt, 1);
        chk("t1_bvalid_clr", bvalid, 0);

        // T2: four beats, one ERROR -> SLVERR
        fifo_q.push_back(2'b00); fifo_q.push_back(2'b00);
        fifo_q.push_back(2'b01); fifo_q.push_back(2'b00);
        expect_b(4'd5, 2'b10);
        pop_cnt = 0;
        push_aw(4'd5, 8'd3);
        drain("t2_drain", 50);
        chk("t2_pops", pop_cnt, 4);
        chk("t2_fifo_left", fifo_q.size(), 0);

        // T3: fill the outstanding queue, overflow, then ordered responses
        for (int i = 1; i <= 4; i++) begin
            expect_b(4'(i), (i == 2 || i == 4) ? 2'b10 : 2'b00);
            push_aw(4'(i), 8'd0);
        end
        chk("t3_aw_full", aw_full, 1);
        chk("t3_ovf_before", ovf_err, 0);
        push_aw(4'd5, 8'd0);
        chk("t3_ovf_err", ovf_err, 1);
        chk("t3_full_held", aw_full, 1);
        fifo_q.push_back(2'b00); fifo_q.push_back(2'b01);
        fifo_q.push_back(2'b00); fifo_q.push_back(2'b11);
        drain("t3_drain", 100);
        tick(2);
        chk("t3_aw_full_clr", aw_full, 0);
        chk("t3_ovf_sticky", ovf_err, 1);
        chk("t3_fifo_left", fifo_q.size(), 0);

        // T4: backpressure holds B stable and blocks further pops
        bready = 1'b0;
        fifo_q.push_back(2'b00);
        expect_b(4'd6, 2'b00);
        push_aw(4'd6, 8'd0);
        n = 0;
        while (!bvalid && n < 50) begin
            tick();
            n++;
        end
        chk("t4_bvalid_seen", bvalid, 1);
        fifo_q.push_back(2'b01);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t4_bvalid_hold", bvalid, 1);
            chk("t4_bid_hold", bid, 6);
            chk("t4_bresp_hold", bresp, 0);
            chk("t4_read_en_low", resp_read_en, 0);
        end
        bready = 1'b1;
        drain("t4_drain", 20);

        // T5: FIFO data with no AW stays unread until an AW arrives
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t5_read_en_low", resp_read_en, 0);
        end
        chk("t5_fifo_kept", fifo_q.size(), 1);
        expect_b(4'd7, 2'b10);
        push_aw(4'd7, 8'd0);
        drain("t5_drain", 50);
        chk("t5_fifo_left", fifo_q.size(), 0);

        // T6: reset in the middle of a 4-beat burst
        fifo_q.push_back(2'b00); fifo_q.push_back(2'b00);
        pop_cnt = 0;
        push_aw(4'd8, 8'd3);
        n = 0;
        while (pop_cnt < 2 && n < 50) begin
            tick();
            n++;
        end
        chk("t6_partial_pops", pop_cnt, 2);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_bvalid", bvalid, 0);
        chk("t6_aw_full", aw_full, 0);
        chk("t6_ovf_clr", ovf_err, 0);
        chk("t6_read_en", resp_read_en, 0);
        fifo_q.push_back(2'b01);
        expect_b(4'd9, 2'b10);
        push_aw(4'd9, 8'd0);
        drain("t6_drain", 50);

        // T7: aw_len=255 is 256 beats; only the final beat reports an error
        for (int i = 0; i < 255; i++) fifo_q.push_back(2'b00);
        fifo_q.push_back(2'b10);
        expect_b(4'd10, 2'b10);
        pop_cnt = 0;
        push_aw(4'd10, 8'd255);
        drain("t7_drain", 400);
        chk("t7_pops", pop_cnt, 256);
        chk("t7_fifo_left", fifo_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "watchdog");
    end

endmodule
